uart_tx_fifo: RTL and testbench

Transmit half of the UART byte path: accepts bytes on a single-cycle `transmit` strobe into a small synchronous FIFO and serialises them on `tx` as 8N1 frames, LSB first. It is the block that sits behind the `tx_byte`/`transmit`/`tx_fifo_full` handshake driven by the echo and command logic at the FPGA top level. It replaces ad-hoc transmitters with one parameterised, FIFO-buffered serialiser.

---
 rtl/uart_tx_fifo.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- FIFO-buffered 8N1 UART transmitter.
//
// Bytes strobed in on `transmit` are queued in a 2^FIFO_AW-entry synchronous
// FIFO and serialised LSB first on `tx` (start, 8 data, stop). Frames are sent
// back to back while the FIFO holds data.
//
// Optional feature macro: UART_TX_PARITY_EN -- when defined, an even parity bit
// is inserted between the last data bit and the stop bit (11-bit frames).
//
// Parameters:
//   CLK_DIV  clock cycles per bit period (2..65535)
//   FIFO_AW  FIFO address width, depth = 2^FIFO_AW
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   tx_byte        byte to enqueue, sampled when transmit=1
//   transmit       push strobe, one byte per high cycle
//   tx             serial line, idles high
//   tx_fifo_full   FIFO holds 2^FIFO_AW bytes
//   tx_fifo_empty  FIFO holds 0 bytes
//   tx_fifo_count  FIFO occupancy
//   busy           a frame is on the line
//   overflow       one-cycle pulse when a push was dropped because FIFO full
module uart_tx_fifo #(
  parameter int CLK_DIV = 868,
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       tx_byte,
  input  logic             transmit,
  output logic             tx,
  output logic             tx_fifo_full,
  output logic             tx_fifo_empty,
  output logic [FIFO_AW:0] tx_fifo_count,
  output logic             busy,
  output logic             overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0]        DIV_M1  = 16'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]   DEPTH_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   CNT_ONE = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

`ifdef UART_TX_PARITY_EN
  // Even parity: the extra bit makes the total number of ones even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`endif

  // FIFO storage and bookkeeping
  logic [7:0]         mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]   count_r;
  logic [FIFO_AW:0]   count_next_s;
  logic               full_r;
  logic               empty_r;
  logic               push_s;
  logic               pop_s;

  // Serialiser state
  state_t      state_r, state_next_s;
  logic [15:0] baud_r, baud_next_s;
  logic [2:0]  bit_idx_r, bit_idx_next_s;
  logic [7:0]  shift_r, shift_next_s;
  logic        tx_next_s;
  logic        tx_r;
  logic        busy_r;
  logic        overflow_r;
`ifdef UART_TX_PARITY_EN
  logic        parity_r, parity_next_s;
`endif

  // Fullness is the registered flag from before this edge, so a push in a
  // full cycle is dropped even if the FSM pops on the same edge.
  assign push_s = transmit & ~full_r;

  // Occupancy update: push and pop together leave the count unchanged.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
  end

  // FIFO write port; storage needs no reset since pointers gate validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= tx_byte;
    end
  end

  // FIFO pointers, count and registered full/empty flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      count_r <= count_next_s;
      full_r  <= (count_next_s == DEPTH_C);
      empty_r <= (count_next_s == '0);
    end
  end

  // Next-state and datapath: each state lasts CLK_DIV cycles, timed by baud_r.
  always_comb begin
    state_next_s   = state_r;
    baud_next_s    = baud_r;
    bit_idx_next_s = bit_idx_r;
    shift_next_s   = shift_r;
    pop_s          = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next_s  = parity_r;
`endif
    case (state_r)
      IDLE: begin
        if (!empty_r) begin
          pop_s        = 1'b1;
          shift_next_s = mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
          parity_next_s = even_parity(mem_r[rd_ptr_r]);
`endif
          baud_next_s  = DIV_M1;
          state_next_s = START;
        end else begin
          baud_next_s  = 16'd0;
        end
      end
      START: begin
        if (baud_r == 16'd0) begin
          state_next_s   = DATA;
          bit_idx_next_s = 3'd0;
          baud_next_s    = DIV_M1;
        end else begin
          baud_next_s    = baud_r - 16'd1;
        end
      end
      DATA: begin
        if (baud_r == 16'd0) begin
          shift_next_s = {1'b0, shift_r[7:1]};
          baud_next_s  = DIV_M1;
          if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next_s = PARITY;
`else
            state_next_s = STOP;
`endif
          end else begin
            bit_idx_next_s = bit_idx_r + 3'd1;
          end
        end else begin
          baud_next_s = baud_r - 16'd1;
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_r == 16'd0) begin
          state_next_s = STOP;
          baud_next_s  = DIV_M1;
        end else begin
          baud_next_s  = baud_r - 16'd1;
        end
      end
`endif
      STOP: begin
        if (baud_r == 16'd0) begin
          baud_next_s = DIV_M1;
          // Chain straight into the next start bit when data is waiting.
          if (!empty_r) begin
            pop_s        = 1'b1;
            shift_next_s = mem_r[rd_ptr_r];
`ifdef UART_TX_PARITY_EN
            parity_next_s = even_parity(mem_r[rd_ptr_r]);
`endif
            state_next_s = START;
          end else begin
            state_next_s = IDLE;
          end
        end else begin
          baud_next_s = baud_r - 16'd1;
        end
      end
      default: begin
        state_next_s = IDLE;
        baud_next_s  = 16'd0;
      end
    endcase
  end

  // Line level for the current state; registered below so tx never glitches.
  always_comb begin
    tx_next_s = 1'b1;
    case (state_r)
      START:   tx_next_s = 1'b0;
      DATA:    tx_next_s = shift_r[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next_s = parity_r;
`endif
      default: tx_next_s = 1'b1;
    endcase
  end

  // FSM and shift-register state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      baud_r    <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
`ifdef UART_TX_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      state_r   <= state_next_s;
      baud_r    <= baud_next_s;
      bit_idx_r <= bit_idx_next_s;
      shift_r   <= shift_next_s;
`ifdef UART_TX_PARITY_EN
      parity_r  <= parity_next_s;
`endif
    end
  end

  // Registered outputs; busy tracks the state with the same lag as tx.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      tx_r       <= tx_next_s;
      busy_r     <= (state_r != IDLE);
      overflow_r <= transmit & full_r;
    end
  end

  assign tx            = tx_r;
  assign busy          = busy_r;
  assign overflow      = overflow_r;
  assign tx_fifo_full  = full_r;
  assign tx_fifo_empty = empty_r;
  assign tx_fifo_count = count_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo (CLK_DIV=4, FIFO_AW=2). Accepted bytes go into a
// scoreboard queue that a line receiver drains; a timeline model derived from
// push times predicts occupancy, overflow, busy and the line every cycle.
module tb_uart_tx_fifo;
  localparam int D = 4;
  localparam int AW = 2;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] tx_byte;
  logic transmit;
  logic tx, tx_fifo_full, tx_fifo_empty, busy, overflow;
  logic [AW:0] tx_fifo_count;

  uart_tx_fifo #(.CLK_DIV(D), .FIFO_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .tx_byte(tx_byte), .transmit(transmit),
    .tx(tx), .tx_fifo_full(tx_fifo_full), .tx_fifo_empty(tx_fifo_empty),
    .tx_fifo_count(tx_fifo_count), .busy(busy), .overflow(overflow));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  // Model: accept edge, pop edge and value per accepted byte; dropped edges.
  int acc_e[$];
  int pop_q[$];
  int drop_e[$];
  logic [7:0] vals[$];
  logic [7:0] exp_q[$];
  int last_pop;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, required %0h", nm, $time, act, req);
    end
  endtask

  function automatic int n_acc_le(input int t);
    int n = 0;
    foreach (acc_e[i]) if (acc_e[i] <= t) n++;
    return n;
  endfunction

  function automatic int n_pop_le(input int t);
    int n = 0;
    foreach (pop_q[i]) if (pop_q[i] <= t) n++;
    return n;
  endfunction

  // A byte pushed at edge e is dropped if the FIFO was full before e;
  // otherwise it leaves the FIFO at the first edge after e at which the line
  // is free, i.e. one full frame after the previous pop.
  task automatic model_push(input logic [7:0] b, input int e);
    int occ, p;
    occ = n_acc_le(e - 1) - n_pop_le(e - 1);
    if (occ >= DEPTH) begin
      drop_e.push_back(e);
    end else begin
      p = e + 1;
      if (pop_q.size() > 0 && last_pop + FB * D > p) p = last_pop + FB * D;
      last_pop = p;
      acc_e.push_back(e);
      pop_q.push_back(p);
      vals.push_back(b);
      exp_q.push_back(b);
    end
  endtask

  task automatic model_clear();
    acc_e.delete(); pop_q.delete(); drop_e.delete(); vals.delete(); exp_q.delete();
    last_pop = 0;
  endtask

  // Drive one cycle of input; returns just after the next rising edge.
  task automatic drive(input logic t, input logic [7:0] b);
    transmit = t;
    tx_byte = b;
    if (t) model_push(b, cyc + 1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    transmit = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Per-cycle monitor against the timeline model (after edge number cyc).
  initial begin
    int t, occ;
    logic exp_tx, exp_busy, exp_ovf;
    int k;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_tx", tx, 1); chk("rst_busy", busy, 0); chk("rst_full", tx_fifo_full, 0);
        chk("rst_empty", tx_fifo_empty, 1); chk("rst_count", tx_fifo_count, 0); chk("rst_ovf", overflow, 0);
      end else begin
        t = cyc;
        occ = n_acc_le(t) - n_pop_le(t);
        exp_tx = 1'b1; exp_busy = 1'b0; exp_ovf = 1'b0;
        foreach (drop_e[i]) if (drop_e[i] == t) exp_ovf = 1'b1;
        foreach (pop_q[i]) begin
          if (t >= pop_q[i] + 1 && t < pop_q[i] + 1 + FB * D) begin
            k = (t - pop_q[i] - 1) / D;
            exp_busy = 1'b1;
            if (k == 0) exp_tx = 1'b0;
            else if (k <= 8) exp_tx = vals[i][k-1];
            else if (k < FB - 1) exp_tx = ^vals[i];
            else exp_tx = 1'b1;
          end
        end
        chk("count", tx_fifo_count, occ);
        chk("full", tx_fifo_full, (occ == DEPTH) ? 1 : 0);
        chk("empty", tx_fifo_empty, (occ == 0) ? 1 : 0);
        chk("overflow", overflow, exp_ovf);
        chk("busy", busy, exp_busy);
        chk("tx", tx, exp_tx);
      end
    end
  end

  // Line receiver: decodes frames mid-bit and pops the scoreboard.
  initial begin
    bit rb = 1'b0;
    int rc = 0;
    int k;
    logic [7:0] rv = 8'h00;
    logic rp = 1'b0;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) rb = 1'b0;
      else if (!rb) begin
        if (tx === 1'b0) begin rb = 1'b1; rc = 0; end
      end else rc++;
      if (rb && rst_n && (rc % D) == D / 2) begin
        k = rc / D;
        if (k == 0) chk("rx_start", tx, 0);
        else if (k <= 8) rv[k-1] = tx;
        else if (k < FB - 1) rp = tx;
        if (k == FB - 1) begin
          chk("rx_stop", tx, 1);
          if (exp_q.size() == 0) chk("rx_unexpected_frame", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("rx_byte", rv, e);
`ifdef UART_TX_PARITY_EN
            chk("rx_parity", rp, ^e);
`endif
          end
          rb = 1'b0;
        end
      end
    end
  end

  initial begin
    logic [7:0] b;
    model_clear();
    rst_n = 1'b0; transmit = 1'b0; tx_byte = 8'h00;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(100);

    // Single byte.
    drive(1'b1, 8'hA5);
    idle(FB * D + 20);

    // Back-to-back frames.
    drive(1'b1, 8'h00); drive(1'b1, 8'hFF); drive(1'b1, 8'h55);
    idle(3 * FB * D + 20);
`ifdef UART_TX_PARITY_EN
    drive(1'b1, 8'h07);
    idle(FB * D + 20);
`endif

    // Overflow: line busy, six pushes into a four-entry FIFO.
    drive(1'b1, 8'h11);
    idle(5);
    for (int i = 0; i < 6; i++) drive(1'b1, 8'(8'h20 + i));
    idle(5 * FB * D + 20);

    // Wrap with pacing near the frame period so pushes hit pop edges.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'($urandom_range(0, 255)));
      if (i >= 2) idle(FB * D - 2 + (i % 3));
    end
    idle(4 * FB * D + 20);

    // Reset during data bit 3 of 0x3C with two bytes queued behind it.
    drive(1'b1, 8'h3C); drive(1'b1, 8'h01); drive(1'b1, 8'h02);
    idle(4 * D + 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", tx, 1); chk("midrst_empty", tx_fifo_empty, 1);
    chk("midrst_count", tx_fifo_count, 0); chk("midrst_busy", busy, 0);
    model_clear();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(100);

    // Random traffic, including overflow bursts.
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom_range(0, 255));
      drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, b);
    end
    idle((DEPTH + 1) * FB * D + 20);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
